// File: rtl/lime_control_unit.sv
// Multicycle control unit: a Moore FSM that sequences fetch, decode, execute,
// memory and write-back, holding in the memory states until mem_ready.
module lime_control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_ALU_EXEC = 4'd2,
        S_ALU_WB   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_HALT     = 4'd15
    } state_e;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       illegal_q, illegal_d;

    // The zero flag is combined with PCWriteCond in the datapath, not here.
    logic unused_zero_s;
    assign unused_zero_s = zero;

    // State, latched opcode and sticky illegal flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_FETCH;
            op_q      <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; the opcode is captured only while in DECODE.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_R, OP_ADDI: state_d = S_ALU_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_HALT:       state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_ALU_EXEC: state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_MEM_ADDR: begin
                if (op_q == OP_LW) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore control decode; FETCH strobes are qualified by mem_ready and reset.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'd0;
        PCSource    = 2'd0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready & RST_N;
                PCWrite = mem_ready & RST_N;
            end
            S_DECODE: ALUSrcB = 2'd3;
            S_ALU_EXEC: begin
                ALUSrcA = 1'b1;
                if (op_q == OP_R) begin
                    ALUSrcB = 2'd0;
                    ALUOp   = 2'd2;
                end else begin
                    ALUSrcB = 2'd2;
                    ALUOp   = 2'd0;
                end
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q == OP_R);
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'd1;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                BranchNE    = (op_q == OP_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            S_HALT: halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_lime_control_unit.sv
// Bench for lime_control_unit: two instances (halt / no-halt on illegal opcodes)
// checked against an instruction-path reference model plus a directed table.
module tb_lime_control_unit;

    logic       CLK;
    logic       RST_N;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pcw1, pcwc1, bne1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rd1, asa1, hlt1, ill1;
    logic [1:0] asb1, aop1, pcs1;
    logic [3:0] st1;
    logic       pcw0, pcwc0, bne0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rd0, asa0, hlt0, ill0;
    logic [1:0] asb0, aop0, pcs0;
    logic [3:0] st0;

    lime_control_unit #(.HALT_ON_ILLEGAL(1'b1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw1), .PCWriteCond(pcwc1), .BranchNE(bne1), .IorD(iord1),
        .MemRead(mrd1), .MemWrite(mwr1), .IRWrite(irw1), .MemtoReg(m2r1),
        .RegWrite(rw1), .RegDst(rd1), .ALUSrcA(asa1), .ALUSrcB(asb1), .ALUOp(aop1),
        .PCSource(pcs1), .halted(hlt1), .illegal(ill1), .state_dbg(st1)
    );

    lime_control_unit #(.HALT_ON_ILLEGAL(1'b0)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw0), .PCWriteCond(pcwc0), .BranchNE(bne0), .IorD(iord0),
        .MemRead(mrd0), .MemWrite(mwr0), .IRWrite(irw0), .MemtoReg(m2r0),
        .RegWrite(rw0), .RegDst(rd0), .ALUSrcA(asa0), .ALUSrcB(asb0), .ALUOp(aop0),
        .PCSource(pcs0), .halted(hlt0), .illegal(ill0), .state_dbg(st0)
    );

    logic [22:0] obs1, obs0;
    assign obs1 = {st1, hlt1, ill1, pcs1, aop1, asb1, pcw1, pcwc1, bne1, iord1, mrd1, mwr1, irw1, m2r1, rw1, rd1, asa1};
    assign obs0 = {st0, hlt0, ill0, pcs0, aop0, asb0, pcw0, pcwc0, bne0, iord0, mrd0, mwr0, irw0, m2r0, rw0, rd0, asa0};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nvec;
    int nfail;

    // Reference model, one per parameter value: current state, latched opcode,
    // sticky illegal, and the remaining state path of the current instruction.
    int         ms[2];
    logic [3:0] mop[2];
    bit         mill[2];
    int         plan[2][4];
    int         plen[2];
    int         pidx[2];

    function automatic logic [22:0] exp_vec(int st, logic [3:0] op, bit mr, bit rst, bit ill);
        logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rd, asa, hlt;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rd, asa, hlt} = 12'd0;
        asb = 2'd0; aop = 2'd0; pcs = 2'd0;
        case (st)
            0:  begin mrd = 1'b1; asb = 2'd1; irw = mr & !rst; pcw = mr & !rst; end
            1:  asb = 2'd3;
            2:  begin asa = 1'b1; asb = (op == 4'd0) ? 2'd0 : 2'd2; aop = (op == 4'd0) ? 2'd2 : 2'd0; end
            3:  begin rw = 1'b1; rd = (op == 4'd0); end
            4:  begin asa = 1'b1; asb = 2'd2; end
            5:  begin iord = 1'b1; mrd = 1'b1; end
            6:  begin rw = 1'b1; m2r = 1'b1; end
            7:  begin iord = 1'b1; mwr = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'd1; pcwc = 1'b1; pcs = 2'd1; bne = (op == 4'd5); end
            9:  begin pcw = 1'b1; pcs = 2'd2; end
            15: hlt = 1'b1;
            default: hlt = 1'b0;
        endcase
        return {4'(st), hlt, ill, pcs, aop, asb, pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rw, rd, asa};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ms[m] = 0; mop[m] = 4'd0; mill[m] = 1'b0; plen[m] = 0; pidx[m] = 0;
        end
    endtask

    task automatic set_plan(int m, int a, int b, int c, int n);
        plan[m][0] = a; plan[m][1] = b; plan[m][2] = c; plen[m] = n; pidx[m] = 0;
    endtask

    task automatic model_step(logic [3:0] op, bit mr);
        for (int m = 0; m < 2; m++) begin
            if (ms[m] == 0) begin
                if (mr) ms[m] = 1;
            end else if (ms[m] == 1) begin
                mop[m] = op;
                if (op <= 4'd1)                      set_plan(m, 2, 3, 0, 2);
                else if (op == 4'd2)                 set_plan(m, 4, 5, 6, 3);
                else if (op == 4'd3)                 set_plan(m, 4, 7, 0, 2);
                else if (op == 4'd4 || op == 4'd5)   set_plan(m, 8, 0, 0, 1);
                else if (op == 4'd6)                 set_plan(m, 9, 0, 0, 1);
                else if (op == 4'd15)                set_plan(m, 15, 0, 0, 1);
                else begin
                    mill[m] = 1'b1;
                    set_plan(m, 15, 0, 0, (m == 1) ? 1 : 0);
                end
                if (plen[m] > 0) begin ms[m] = plan[m][0]; pidx[m] = 1; end
                else ms[m] = 0;
            end else if (ms[m] == 15) begin
                ms[m] = 15;
            end else if ((ms[m] == 5 || ms[m] == 7) && !mr) begin
                ms[m] = ms[m];
            end else begin
                if (pidx[m] < plen[m]) begin ms[m] = plan[m][pidx[m]]; pidx[m]++; end
                else ms[m] = 0;
            end
        end
    endtask

    task automatic check_all(string tag);
        logic [22:0] e, g;
        for (int m = 0; m < 2; m++) begin
            e = exp_vec(ms[m], mop[m], mem_ready, !RST_N, mill[m]);
            g = (m == 1) ? obs1 : obs0;
            nvec++;
            if (g !== e) begin
                nfail++;
                $display("FAIL %s_p%0d t=%0t got=%h expected=%h", tag, m, $time, g, e);
            end
        end
    endtask

    task automatic drive_check(logic [3:0] op, logic z, logic mr, string tag);
        opcode = op; zero = z; mem_ready = mr;
        #2;
        check_all(tag);
    endtask

    task automatic clock_step();
        @(posedge CLK);
        model_step(opcode, mem_ready);
        #1;
    endtask

    logic [3:0] st_at_rst;
    logic       mw_at_rst;

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        #1;
        st_at_rst = st1;
        mw_at_rst = mwr1;
        check_all("reset");
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
    endtask

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, want);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic       mr;
        logic [3:0] st;
        logic [8:0] flags; // RegWrite RegDst MemRead IorD MemtoReg PCWriteCond BranchNE halted illegal
    } vec_t;

    vec_t tbl[25];
    int   halt_cnt;

    initial begin
        nvec = 0; nfail = 0;
        RST_N = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
        model_reset();
        #1;
        do_reset();

        tbl[0]  = '{4'd0, 1'b1, 4'd0,  9'b001000000};
        tbl[1]  = '{4'd0, 1'b1, 4'd1,  9'b000000000};
        tbl[2]  = '{4'd0, 1'b1, 4'd2,  9'b000000000};
        tbl[3]  = '{4'd0, 1'b1, 4'd3,  9'b110000000};
        tbl[4]  = '{4'd2, 1'b1, 4'd0,  9'b001000000};
        tbl[5]  = '{4'd2, 1'b1, 4'd1,  9'b000000000};
        tbl[6]  = '{4'd2, 1'b1, 4'd4,  9'b000000000};
        tbl[7]  = '{4'd2, 1'b0, 4'd5,  9'b001100000};
        tbl[8]  = '{4'd2, 1'b0, 4'd5,  9'b001100000};
        tbl[9]  = '{4'd2, 1'b0, 4'd5,  9'b001100000};
        tbl[10] = '{4'd2, 1'b1, 4'd5,  9'b001100000};
        tbl[11] = '{4'd2, 1'b1, 4'd6,  9'b100010000};
        tbl[12] = '{4'd0, 1'b1, 4'd0,  9'b001000000};
        tbl[13] = '{4'd0, 1'b1, 4'd1,  9'b000000000};
        tbl[14] = '{4'd1, 1'b1, 4'd2,  9'b000000000};
        tbl[15] = '{4'd1, 1'b1, 4'd3,  9'b110000000};
        tbl[16] = '{4'd5, 1'b1, 4'd0,  9'b001000000};
        tbl[17] = '{4'd5, 1'b1, 4'd1,  9'b000000000};
        tbl[18] = '{4'd5, 1'b1, 4'd8,  9'b000001100};
        tbl[19] = '{4'd4, 1'b1, 4'd0,  9'b001000000};
        tbl[20] = '{4'd4, 1'b1, 4'd1,  9'b000000000};
        tbl[21] = '{4'd4, 1'b1, 4'd8,  9'b000001000};
        tbl[22] = '{4'd9, 1'b1, 4'd0,  9'b001000000};
        tbl[23] = '{4'd9, 1'b1, 4'd1,  9'b000000000};
        tbl[24] = '{4'd9, 1'b1, 4'd15, 9'b000000011};

        for (int i = 0; i < 25; i++) begin
            drive_check(tbl[i].op, 1'b0, tbl[i].mr, "table_model");
            cmp($sformatf("table_state_%0d", i), {28'd0, st1}, {28'd0, tbl[i].st});
            cmp($sformatf("table_flags_%0d", i),
                {23'd0, rw1, rd1, mrd1, iord1, m2r1, pcwc1, bne1, hlt1, ill1},
                {23'd0, tbl[i].flags});
            if (i == 24) begin
                cmp("noHalt_state", {28'd0, st0}, 32'd0);
                cmp("noHalt_illegal", {31'd0, ill0}, 32'd1);
            end
            clock_step();
        end

        // Halted instance must stay put for 20 cycles whatever the inputs do.
        for (int i = 0; i < 20; i++) begin
            drive_check(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), "halt_hold");
            cmp("halt_hold_halted", {31'd0, hlt1}, 32'd1);
            clock_step();
        end

        // Store interrupted by reset while waiting for memory.
        do_reset();
        drive_check(4'd3, 1'b0, 1'b1, "sw_fetch");   clock_step();
        drive_check(4'd3, 1'b0, 1'b1, "sw_decode");  clock_step();
        drive_check(4'd3, 1'b0, 1'b1, "sw_addr");    clock_step();
        drive_check(4'd3, 1'b0, 1'b0, "sw_wait");
        cmp("sw_wait_memwrite", {31'd0, mwr1}, 32'd1);
        clock_step();
        drive_check(4'd3, 1'b0, 1'b0, "sw_wait2");
        do_reset();
        cmp("rst_mid_wr_state", {28'd0, st_at_rst}, 32'd0);
        cmp("rst_mid_wr_memwrite", {31'd0, mw_at_rst}, 32'd0);
        drive_check(4'd6, 1'b0, 1'b1, "post_rst_fetch");
        clock_step();
        cmp("post_rst_decode", {28'd0, st1}, 32'd1);
        drive_check(4'd6, 1'b0, 1'b1, "jump_decode");   clock_step();
        drive_check(4'd6, 1'b0, 1'b1, "jump_exec");     clock_step();

        // Randomized traffic with occasional resets.
        halt_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0 || halt_cnt > 3) begin
                do_reset();
                halt_cnt = 0;
            end
            drive_check(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), "random");
            clock_step();
            if (ms[1] == 15) halt_cnt++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
